// File: rtl/vu_frame_scheduler.sv
// rtl/vu_frame_scheduler.sv - VU meter frame scheduler: per-frame level max, committed at v_sync
//
// Purpose:
//   Accepts audio level samples over a valid/ready handshake and keeps the
//   largest level seen during the current frame. At the start of vertical
//   sync the frame maximum and the peak-hold marker are committed together,
//   so the renderer never sees a change in the middle of a frame.
//
// Ports:
//   clock_i         pixel clock
//   reset_i         asynchronous, active-high reset
//   v_sync_i        vertical sync from vga_controller (active level V_POL)
//   sample_valid_i  level sample offered
//   sample_ready_o  sample accepted this cycle when valid is also high
//   sample_level_i  level sample (saturated to MAX_LEVEL)
//   level_out_o     committed bar level, stable for a whole frame
//   peak_out_o      committed peak-hold marker level
//   commit_o        one-cycle pulse on the cycle level/peak update
//
// Configuration:
//   VU_PEAK_HOLD_EN  defined: peak is held HOLD_FRAMES commits, then decays
//                    by DECAY_STEP per commit down to the current level.
//                    undefined: peak_out_o follows level_out_o on every commit.

module vu_frame_scheduler #(
  parameter int LVL_W       = 5,
  parameter int MAX_LEVEL   = 16,
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY_STEP  = 1,
  parameter int V_POL       = 0
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             v_sync_i,
  input  logic             sample_valid_i,
  output logic             sample_ready_o,
  input  logic [LVL_W-1:0] sample_level_i,
  output logic [LVL_W-1:0] level_out_o,
  output logic [LVL_W-1:0] peak_out_o,
  output logic             commit_o
);

  localparam logic [LVL_W-1:0] MaxLvl = LVL_W'(MAX_LEVEL);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_ACCUM  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t           state_q;
  logic             vs_prev_q;
  logic             ready_q;
  logic             commit_q;
  logic [LVL_W-1:0] accum_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] peak_q;
  logic [LVL_W-1:0] peak_d;

  logic             vs_act;
  logic             frame_edge;
  logic             handshake;
  logic [LVL_W-1:0] sat_level;
  logic [LVL_W-1:0] accum_max;

  // Rising edge of the active sync level: a long sync pulse yields one edge.
  assign vs_act     = (v_sync_i == 1'(V_POL));
  assign frame_edge = vs_act & ~vs_prev_q;
  assign handshake  = sample_valid_i & ready_q;

  // Saturate before comparing so an oversized sample counts as MAX_LEVEL.
  assign sat_level = (sample_level_i > MaxLvl) ? MaxLvl : sample_level_i;
  assign accum_max = (sat_level > accum_q) ? sat_level : accum_q;

`ifdef VU_PEAK_HOLD_EN
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [LVL_W-1:0]  DecayStep = LVL_W'(DECAY_STEP);
  localparam logic [HOLD_W-1:0] HoldInit  = HOLD_W'(HOLD_FRAMES);

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic [LVL_W-1:0]  decayed;

  // Decay saturates at zero, then is floored at the new level so the
  // marker never sits below the bar it is drawn over.
  assign decayed = (peak_q > DecayStep) ? (peak_q - DecayStep) : '0;

  always_comb begin
    peak_d = peak_q;
    hold_d = hold_q;
    if (accum_q >= peak_q) begin
      peak_d = accum_q;
      hold_d = HoldInit;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end else begin
      peak_d = (decayed > accum_q) ? decayed : accum_q;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      hold_q <= '0;
    end else if (state_q == S_COMMIT) begin
      hold_q <= hold_d;
    end
  end
`else
  assign peak_d = accum_q;

  // Hold/decay parameters only shape the peak-hold build.
  if (HOLD_FRAMES < 0 || DECAY_STEP < 0) begin : g_unused_hold_cfg
  end
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_WAIT;
      vs_prev_q <= 1'b0;
      ready_q   <= 1'b0;
      commit_q  <= 1'b0;
      accum_q   <= '0;
      level_q   <= '0;
      peak_q    <= '0;
    end else begin
      vs_prev_q <= vs_act;
      commit_q  <= 1'b0;
      case (state_q)
        S_WAIT: begin
          // Nothing is committed until one full frame has been observed.
          if (frame_edge) begin
            state_q <= S_ACCUM;
            accum_q <= '0;
            ready_q <= 1'b1;
          end
        end
        S_ACCUM: begin
          // A sample on the edge cycle still belongs to the closing frame.
          if (handshake) begin
            accum_q <= accum_max;
          end
          if (frame_edge) begin
            state_q <= S_COMMIT;
            ready_q <= 1'b0;
          end
        end
        S_COMMIT: begin
          level_q  <= accum_q;
          peak_q   <= peak_d;
          accum_q  <= '0;
          commit_q <= 1'b1;
          state_q  <= S_ACCUM;
          ready_q  <= 1'b1;
        end
        default: begin
          state_q <= S_WAIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign sample_ready_o = ready_q;
  assign level_out_o    = level_q;
  assign peak_out_o     = peak_q;
  assign commit_o       = commit_q;

endmodule
